// File: rtl/bt_radio_seq_pkg.sv
// bt_radio_seq_pkg: shared state encoding, timing defaults and field widths for the BT radio sequencer
package bt_radio_seq_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_e;
  localparam int DEF_SETTLE_CYC = 720;
  localparam int DEF_BIT_CYC = 6;
  localparam int DEF_SAMPLE_PH = 3;
  localparam int FK_W = 7;
  localparam int NBITS_W = 12;
endpackage

// File: rtl/bt_bit_timer.sv
// bt_bit_timer: air-bit phase counter; clk_6M/rstz clock+async reset, clr holds phase 0,
// ph_sample strobes at SAMPLE_PH, ph_last strobes at BIT_CYC-1
module bt_bit_timer
  import bt_radio_seq_pkg::*;
#(
  parameter int BIT_CYC = DEF_BIT_CYC,
  parameter int SAMPLE_PH = DEF_SAMPLE_PH
) (
  input  logic clk_6M,
  input  logic rstz,
  input  logic clr,
  output logic ph_sample,
  output logic ph_last
);
  localparam int PW = BIT_CYC > 1 ? $clog2(BIT_CYC) : 1;
  logic [PW-1:0] ph_q, ph_d;
  assign ph_last = ph_q == PW'(BIT_CYC - 1);
  assign ph_sample = ph_q == PW'(SAMPLE_PH);
  always_comb ph_d = (clr || ph_last) ? '0 : ph_q + 1'b1;
  always_ff @(posedge clk_6M or negedge rstz)
    if (!rstz) ph_q <= '0;
    else ph_q <= ph_d;
endmodule

// File: rtl/bt_radio_seq.sv
// bt_radio_seq: sequences one TX/RX radio burst (freq load, PLL settle, bit-serial run)
// Ports: req_* burst request; abort; tx_data/tx_valid/tx_ready byte stream in;
// rx_data/rx_valid byte stream out; rxbitout, lc_fk, loadfreq_p, txen, rxen, txbitin radio side;
// busy, done_p, err status.
module bt_radio_seq
  import bt_radio_seq_pkg::*;
#(
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int BIT_CYC = DEF_BIT_CYC,
  parameter int SAMPLE_PH = DEF_SAMPLE_PH
) (
  input  logic               clk_6M,
  input  logic               rstz,
  input  logic               req_p,
  input  logic               req_tx,
  input  logic [FK_W-1:0]    req_fk,
  input  logic [NBITS_W-1:0] req_nbits,
  input  logic               abort,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  input  logic               rxbitout,
  output logic [FK_W-1:0]    lc_fk,
  output logic               loadfreq_p,
  output logic               txen,
  output logic               rxen,
  output logic               txbitin,
  output logic               busy,
  output logic               done_p,
  output logic               err
);
  localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  state_e state_q, state_d;
  logic [SW-1:0] set_q, set_d;
  logic [NBITS_W-1:0] nb_q, nb_d;
  logic [FK_W-1:0] fk_q, fk_d;
  logic [8:0] sr_q, sr_d, sr_ld;
  logic [3:0] cnt_q, cnt_d, cnt_ld;
  logic [2:0] rbit_q, rbit_d;
  logic [7:0] rsr_q, rsr_d, rx_new, rx_data_q, rx_data_d;
  logic tx_q, tx_d, rx_valid_q, rx_valid_d, done_q, done_d, err_q, err_d;
  logic ph_sample, ph_last, xfer, uf, fin;
  bt_bit_timer #(.BIT_CYC(BIT_CYC), .SAMPLE_PH(SAMPLE_PH)) u_timer (
    .clk_6M,
    .rstz,
    .clr(state_q != RUN),
    .ph_sample,
    .ph_last
  );
  // The shift register is 9 bits wide so a byte accepted while the last bit of the
  // previous byte is still on air can be stacked above it without a gap.
  assign tx_ready = tx_q && !abort && (state_q == SETTLE || state_q == RUN) &&
                    cnt_q <= 4'd1 && nb_q > NBITS_W'(cnt_q);
  assign xfer = tx_valid && tx_ready;
  assign sr_ld = xfer ? sr_q | (9'(tx_data) << cnt_q) : sr_q;
  assign cnt_ld = xfer ? cnt_q + 4'd8 : cnt_q;
  assign rx_new = rsr_q | (8'(rxbitout) << rbit_q);
  always_comb begin
    state_d = state_q;
    set_d = set_q;
    nb_d = nb_q;
    tx_d = tx_q;
    fk_d = fk_q;
    sr_d = sr_ld;
    cnt_d = cnt_ld;
    rbit_d = rbit_q;
    rsr_d = rsr_q;
    rx_data_d = rx_data_q;
    rx_valid_d = 1'b0;
    done_d = 1'b0;
    err_d = err_q;
    uf = 1'b0;
    fin = 1'b0;
    unique case (state_q)
      IDLE: if (req_p && req_nbits != '0) begin
        state_d = LOAD;
        tx_d = req_tx;
        nb_d = req_nbits;
        fk_d = req_fk;
        err_d = 1'b0;
        sr_d = '0;
        cnt_d = '0;
        rbit_d = '0;
        rsr_d = '0;
      end
      LOAD: begin
        state_d = SETTLE;
        set_d = '0;
      end
      SETTLE: begin
        set_d = set_q + 1'b1;
        if (set_q == SW'(SETTLE_CYC - 1)) begin
          state_d = RUN;
          uf = tx_q && cnt_ld == '0;
        end
      end
      RUN: begin
        if (!tx_q && ph_sample) begin
          rsr_d = rx_new;
          rbit_d = rbit_q + 1'b1;
          if (rbit_q == 3'd7 || nb_q == NBITS_W'(1)) begin
            rx_valid_d = 1'b1;
            rx_data_d = rx_new;
            rsr_d = '0;
          end
        end
        if (ph_last) begin
          nb_d = nb_q - 1'b1;
          fin = nb_q == NBITS_W'(1);
          // Register would be empty entering a bit that is still owed.
          uf = tx_q && !fin && cnt_ld <= 4'd1;
          if (tx_q) begin
            sr_d = sr_ld >> 1;
            cnt_d = cnt_ld - 4'd1;
          end
        end
      end
      default: ;
    endcase
    if (uf) begin
      err_d = 1'b1;
      fin = 1'b1;
    end
    if (state_q != IDLE && abort) begin
      fin = 1'b1;
      err_d = 1'b1;
      rx_valid_d = 1'b0;
      rx_data_d = rx_data_q;
    end
    if (fin) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk_6M or negedge rstz)
    if (!rstz) begin
      state_q <= IDLE;
      set_q <= '0;
      nb_q <= '0;
      tx_q <= 1'b0;
      fk_q <= '0;
      sr_q <= '0;
      cnt_q <= '0;
      rbit_q <= '0;
      rsr_q <= '0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q <= set_d;
      nb_q <= nb_d;
      tx_q <= tx_d;
      fk_q <= fk_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      rbit_q <= rbit_d;
      rsr_q <= rsr_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign loadfreq_p = state_q == LOAD;
  assign txen = state_q == RUN && tx_q;
  assign rxen = state_q == RUN && !tx_q;
  assign txbitin = txen && sr_q[0];
  assign busy = state_q != IDLE;
  assign done_p = done_q;
  assign err = err_q;
  assign lc_fk = fk_q;
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
endmodule

// File: tb/tb_bt_radio_seq.sv
// tb_bt_radio_seq: scoreboard bench for bt_radio_seq with directed bursts
module tb_bt_radio_seq;
  logic clk_6M = 1'b0, rstz = 1'b0, req_p = 1'b0, req_tx = 1'b0, abort = 1'b0;
  logic tx_valid = 1'b0, rxbitout = 1'b0, tk = 1'b0;
  logic [6:0] req_fk = '0;
  logic [11:0] req_nbits = '0;
  logic [7:0] tx_data = '0;
  logic tx_ready, rx_valid, loadfreq_p, txen, rxen, txbitin, busy, done_p, err;
  logic [7:0] rx_data;
  logic [6:0] lc_fk;
  int cycnt = 0, t0 = 0, checks = 0, errors = 0, en_cnt = 0, nbits_cur = 0, rr = 0;
  logic rx_mode = 1'b0;
  logic [15:0] rx_pat = '0;
  localparam int K_LOAD = 0, K_BIT = 1, K_RX = 2, K_DONE = 3;
  typedef struct {int kind; int cyc; int val; int aux;} ev_t;
  ev_t sbq[$];
  logic [7:0] txq[$];
  bt_radio_seq dut (
    .clk_6M(clk_6M), .rstz(rstz), .req_p(req_p), .req_tx(req_tx), .req_fk(req_fk),
    .req_nbits(req_nbits), .abort(abort), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rxbitout(rxbitout),
    .lc_fk(lc_fk), .loadfreq_p(loadfreq_p), .txen(txen), .rxen(rxen), .txbitin(txbitin),
    .busy(busy), .done_p(done_p), .err(err)
  );
  always #5 clk_6M = ~clk_6M;
  always @(posedge clk_6M) cycnt <= cycnt + 1;
  function automatic int outs();
    return int'({lc_fk, loadfreq_p, txen, rxen, txbitin, tx_ready, rx_valid, done_p, busy, err, rx_data});
  endfunction
  task automatic expect_ev(int k, int c, int v, int a);
    sbq.push_back('{k, c, v, a});
  endtask
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic sb_pop(int k, int c, int v, int a);
    ev_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind %0d cyc %0d val %0h aux %0d with nothing expected", k, c, v, a);
    end else begin
      e = sbq.pop_front();
      if (e.kind != k || e.cyc != c || e.val != v || e.aux != a) begin
        errors++;
        $display("FAIL event: got kind %0d cyc %0d val %0h aux %0d, expected kind %0d cyc %0d val %0h aux %0d",
                 k, c, v, a, e.kind, e.cyc, e.val, e.aux);
      end
    end
  endtask
  always @(negedge clk_6M) begin
    if (!rstz) en_cnt = 0;
    else begin
      if (txen || rxen) en_cnt++;
      if (loadfreq_p) sb_pop(K_LOAD, cycnt - t0, int'(lc_fk), int'({busy, err}));
      if (txen && (cycnt - t0 - 722) % 6 == 0) sb_pop(K_BIT, cycnt - t0, int'(txbitin), 0);
      if (rx_valid) sb_pop(K_RX, cycnt - t0, int'(rx_data), 0);
      if (done_p) begin
        sb_pop(K_DONE, cycnt - t0, int'(err), en_cnt * 2 + int'(txen | rxen));
        en_cnt = 0;
      end
    end
  end
  always begin
    @(negedge clk_6M);
    tk = tx_valid && tx_ready;
    @(posedge clk_6M);
    #1;
    if (tk && txq.size() != 0) void'(txq.pop_front());
    tx_valid = txq.size() != 0;
    tx_data = tx_valid ? txq[0] : 8'h00;
  end
  always @(posedge clk_6M) begin
    #1;
    rr = cycnt - t0;
    rxbitout = (rx_mode && rr >= 722 && rr < 722 + 6 * nbits_cur) ? rx_pat[4'((rr - 722) / 6)] : 1'b0;
  end
  task automatic tick();
    @(posedge clk_6M);
    #1;
  endtask
  task automatic goto(int rel);
    while (cycnt - t0 < rel) tick();
  endtask
  task automatic start(logic tx, logic [6:0] fk, int n);
    t0 = cycnt;
    req_p = 1'b1;
    req_tx = tx;
    req_fk = fk;
    req_nbits = 12'(n);
    nbits_cur = n;
    rx_mode = !tx;
    tick();
    req_p = 1'b0;
  endtask
  task automatic wait_done(string name);
    int n = 0;
    do begin
      @(negedge clk_6M);
      n++;
    end while (!done_p && n < 2000);
    checks++;
    if (!done_p) begin
      errors++;
      $display("FAIL %s: done_p absent after %0d cycles, required within 2000", name, n);
    end
  endtask
  task automatic exp_tx_bits(logic [15:0] bits, int n);
    for (int i = 0; i < n; i++) expect_ev(K_BIT, 722 + 6 * i, int'(bits[i]), 0);
  endtask
  initial begin
    repeat (3) @(posedge clk_6M);
    #1;
    chk("reset_outs", outs(), 0);
    rstz = 1'b1;
    txq.push_back(8'hA5);
    txq.push_back(8'h3C);
    expect_ev(K_LOAD, 1, 'h27, 2);
    exp_tx_bits(16'h3CA5, 16);
    expect_ev(K_DONE, 818, 0, 192);
    tick();
    start(1'b1, 7'h27, 16);
    wait_done("tx_burst");
    chk("tx_err", err, 0);
    rx_pat = 16'h0F0F;
    expect_ev(K_LOAD, 1, 'h05, 2);
    expect_ev(K_RX, 768, 'h0F, 0);
    expect_ev(K_RX, 792, 'h0F, 0);
    expect_ev(K_DONE, 794, 0, 144);
    tick();
    start(1'b0, 7'h05, 12);
    goto(750);
    chk("busy_before_ignored_req", busy, 1);
    req_p = 1'b1;
    req_tx = 1'b1;
    req_nbits = 12'd5;
    tick();
    req_p = 1'b0;
    chk("busy_after_ignored_req", busy, 1);
    wait_done("rx_burst");
    chk("rx_err", err, 0);
    txq.push_back(8'hFF);
    expect_ev(K_LOAD, 1, 'h11, 2);
    exp_tx_bits(16'h00FF, 8);
    expect_ev(K_DONE, 770, 1, 96);
    tick();
    start(1'b1, 7'h11, 16);
    wait_done("underrun");
    chk("underrun_err", err, 1);
    chk("underrun_txen", txen, 0);
    rx_pat = 16'h005A;
    expect_ev(K_LOAD, 1, 'h40, 2);
    expect_ev(K_DONE, 301, 1, 0);
    expect_ev(K_LOAD, 1, 'h12, 2);
    expect_ev(K_RX, 768, 'h5A, 0);
    expect_ev(K_DONE, 770, 0, 96);
    tick();
    start(1'b0, 7'h40, 8);
    goto(300);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done("abort");
    chk("abort_err", err, 1);
    goto(305);
    start(1'b0, 7'h12, 8);
    wait_done("after_abort");
    chk("after_abort_err", err, 0);
    tick();
    req_p = 1'b1;
    req_tx = 1'b1;
    req_nbits = 12'd0;
    tick();
    req_p = 1'b0;
    repeat (3) tick();
    chk("zero_nbits_busy", busy, 0);
    txq.push_back(8'hA5);
    txq.push_back(8'h3C);
    expect_ev(K_LOAD, 1, 'h33, 2);
    exp_tx_bits(16'h0005, 3);
    tick();
    start(1'b1, 7'h33, 16);
    goto(740);
    rstz = 1'b0;
    #1;
    chk("midrun_reset_outs", outs(), 0);
    txq.delete();
    tick();
    tick();
    rstz = 1'b1;
    chk("sb_drained_at_reset", sbq.size(), 0);
    expect_ev(K_LOAD, 1, 'h12, 2);
    expect_ev(K_RX, 768, 'h5A, 0);
    expect_ev(K_DONE, 770, 0, 96);
    tick();
    start(1'b0, 7'h12, 8);
    wait_done("post_reset");
    tick();
    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bt_radio_seq.md
# bt_radio_seq

Link-controller-side sequencer that drives the BT radio model for a single TX or RX burst. It loads the hop frequency (pulses `loadfreq_p` with `lc_fk`) and waits out PLL settling. It then enables the radio and either serializes payload bytes onto `txbitin` or samples `rxbitout` into bytes, one bit per 1 µs (6 cycles of `clk_6M`). It sits between the baseband packet logic (byte valid/ready streams) and the radio port.

## Interface
- `SETTLE_CYC`, 720: cycles from `loadfreq_p` to radio enable (120 µs; covers the 600-cycle PLL lock plus margin).
- `BIT_CYC`, 6: clocks per air bit.
- `SAMPLE_PH`, 3: phase (0..BIT_CYC-1) at which an RX bit is sampled.
- `clk_6M` in 1: 6 MHz clock.
- `rstz` in 1: asynchronous active-low reset.
- `req_p` in 1: one-cycle burst request; sampled only in IDLE.
- `req_tx` in 1: 1 = TX burst, 0 = RX burst.
- `req_fk` in 7: channel index k.
- `req_nbits` in 12: burst length in bits, 1..4095; 0 ignores the request.
- `abort` in 1: terminate any burst immediately.
- `tx_data` in 8: TX byte, sent LSB first.
- `tx_valid` in 1: TX byte available.
- `tx_ready` out 1: sequencer accepts a byte this cycle (transfer = `tx_valid & tx_ready`).
- `rx_data` out 8: RX byte, first-received bit in bit 0.
- `rx_valid` out 1: one-cycle strobe qualifying `rx_data`.
- `rxbitout` in 1: bit from the radio.
- `lc_fk` out 7: frequency to the radio.
- `loadfreq_p` out 1: one-cycle PLL load strobe.
- `txen`, `rxen` out 1: radio enables (never both high).
- `txbitin` out 1: bit to the radio.
- `busy` out 1: high in any state other than IDLE.
- `done_p` out 1: one-cycle end-of-burst strobe.
- `err` out 1: sticky; set by underrun or abort, cleared by the next accepted request.

## Operation
- States: IDLE → LOAD → SETTLE → RUN → IDLE.
- IDLE, `req_p & req_nbits!=0`: latch `req_tx`, `req_nbits`, and `req_fk` into `lc_fk`; clear `err`; go to LOAD.
- LOAD (1 cycle): `loadfreq_p=1`; go to SETTLE with settle counter = 0.
- SETTLE: counter runs 0..SETTLE_CYC-1, then RUN. For TX, `tx_ready=1` while the shift register is empty.
- RUN: `txen` or `rxen` = 1; bit-phase counter runs 0..BIT_CYC-1; bit counter counts down from `req_nbits`.
- TX in RUN:
  - `txbitin` = shift-register bit 0, held for the whole bit period.
  - Shift at phase BIT_CYC-1.
  - After the 8th bit of a byte, the register is empty. `tx_ready=1` while it is empty and bits remain.
  - If the register is empty at phase 0 of a bit that is still owed, that is an underrun: set `err`, end the burst.
- RX in RUN:
  - At phase SAMPLE_PH, shift `rxbitout` into bit position (bit index mod 8).
  - On the 8th bit, or on the final bit of the burst, pulse `rx_valid` the next cycle. Unfilled upper bits read 0.
- Burst end (last bit's phase BIT_CYC-1, underrun, or abort): next cycle `txen=rxen=0`, `txbitin=0`, `done_p=1`, state IDLE.
- `lc_fk` holds its value until the next request.
- `abort` has priority over every other event in every non-IDLE state. It sets `err`, does not emit a partial RX byte, and behaves as burst end. `abort` in IDLE has no effect.
- `req_p` while `busy` is ignored.
- A TX byte offered after the last needed bit is not accepted (`tx_ready=0`).

## Timing
- Reset values: `lc_fk=0`; `loadfreq_p=txen=rxen=txbitin=tx_ready=rx_valid=done_p=busy=err=0`; `rx_data=0`.
- Latencies from `req_p` in cycle 0:
  - `loadfreq_p` in cycle 1.
  - Enable rises in cycle 2+SETTLE_CYC (default 722).
  - Bit n occupies cycles 722+6n .. 727+6n.
  - `done_p` and enable fall in cycle 722+6·N, where N = `req_nbits`.
- An RX byte whose last bit is sampled in cycle c strobes `rx_valid` in c+1.
- A TX byte transferred in SETTLE or during bit 7 of the previous byte is used with no gap.
- Reset mid-burst: all outputs return to reset values asynchronously.

## Structure
- Shared package holds:
  - State enum (IDLE, LOAD, SETTLE, RUN).
  - Defaults SETTLE_CYC, BIT_CYC, SAMPLE_PH.
  - Widths FK_W=7, NBITS_W=12.
- One sub-module, `bt_bit_timer`: bit-phase counter producing `ph_sample` and `ph_last` strobes; reset on RUN entry.

## Test plan
- TX, k=0x27, nbits=16, bytes 0xA5, 0x3C offered early:
  - `loadfreq_p` at cycle 1 with `lc_fk=0x27`.
  - `txen` cycles 722..817; `txbitin` sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - `done_p` at cycle 818.
- RX, nbits=12, `rxbitout` driving pattern 0xF0F, 6 cycles per bit: `rx_valid` with 0x0F, then 0x0F (upper nibble 0); `err=0`.
- TX underrun: nbits=16, only 0xFF supplied → `err=1`, `done_p` at cycle 722+48, `txen` low after it.
- Abort at cycle 300 (SETTLE) → no enable ever rises, `done_p` at 301, `err=1`; a new `req_p` at 305 is accepted and clears `err`.
- Ignored requests: `req_p` during RUN and `req_p` with nbits=0 → no `loadfreq_p`, `busy` unchanged.
- Assert `rstz` low mid-RUN → all outputs 0 immediately; next request runs normally.
